// File: rtl/shift_seq_if.sv
// shift_seq_if: control/datapath bundle between the ALU controller and the shift sequencer
//   master: drives start, op, data_in, shamt, flush; observes busy, done, result
//   slave : the sequencer side of the same signals
interface shift_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, data_in, shamt, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data_in, shamt, flush,
        output busy, done, result
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle SLL/SRL/SRA/ROTR sequencer applying one 1-bit step per clock
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : shift_seq_if.slave (start/op/data_in/shamt/flush in, busy/done/result out)
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_seq_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [SHW-1:0]   count_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] step_d;

    // SRA and ROTR differ only in the bit shifted into the MSB
    always_comb begin
        step_d = (op_q == 2'b00) ? {result_q[WIDTH-2:0], 1'b0} :
                 (op_q == 2'b01) ? {1'b0, result_q[WIDTH-1:1]} :
                 {(op_q[0] ? result_q[0] : result_q[WIDTH-1]), result_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            count_q  <= '0;
            op_q     <= 2'b00;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                // abort wins over everything, including a simultaneous start in IDLE
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (bus.start) begin
                        result_q <= bus.data_in;
                        op_q     <= bus.op;
                        count_q  <= bus.shamt;
                        busy_q   <= 1'b1;
                        state_q  <= (bus.shamt == '0) ? DONE : SHIFT;
                        done_q   <= (bus.shamt == '0);
                    end
                    SHIFT: begin
                        result_q <= step_d;
                        count_q  <= count_q - 1'b1;
                        if (count_q == SHW'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
